// File: rtl/popshift_loadmod.sv
// popshift_loadmod: parallel-to-stream nibble unloader.
// Latches a packed word of NIBBLES 4-bit digits and replays it MS nibble
// first as one-cycle write strobes (oEn/oAddr/oData), STEP_CYCLES apart.
// Optional feature macro: POPSHIFT_ADDR_INC_EN
//   defined   -> address increments (mod 16) after every emitted nibble
//   undefined -> every nibble is written to iBaseAddr
module popshift_loadmod #(
    parameter int NIBBLES     = 6,
    parameter int STEP_CYCLES = 50_000_000,
    parameter int CNT_W       = 32
) (
    input  logic                 sysclk,
    input  logic                 rst_n,
    input  logic                 iLoad,
    input  logic [4*NIBBLES-1:0] iData,
    input  logic [3:0]           iBaseAddr,
    input  logic                 iHold,
    output logic                 oEn,
    output logic [3:0]           oAddr,
    output logic [3:0]           oData,
    output logic                 oBusy,
    output logic                 oDone
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);
    // WAIT exits on this count; with STEP_CYCLES=1 WAIT is never entered
    localparam logic [CNT_W-1:0] CNT_LAST =
        (STEP_CYCLES > 1) ? CNT_W'(STEP_CYCLES - 2) : '0;
    localparam bit BACK_TO_BACK = (STEP_CYCLES <= 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT,
        S_WAIT,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [W-1:0]     shadow_q, shadow_d;
    logic [3:0]       addr_q, addr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // last strobed nibble/address, so outputs hold between strobes
    logic [3:0]       last_data_q, last_data_d;
    logic [3:0]       last_addr_q, last_addr_d;
    logic [3:0]       cur_nib;

    assign cur_nib = shadow_q[W-1 -: 4];

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            shadow_q    <= '0;
            addr_q      <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            last_data_q <= '0;
            last_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            addr_q      <= addr_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            last_data_q <= last_data_d;
            last_addr_q <= last_addr_d;
        end
    end

    // Next-state logic: load, emit/shift, paced wait, done pulse
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        addr_d      = addr_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        last_data_d = last_data_q;
        last_addr_d = last_addr_q;
        case (state_q)
            S_IDLE: begin
                // loads are only accepted here; iHold is irrelevant
                if (iLoad) begin
                    shadow_d = iData;
                    addr_d   = iBaseAddr;
                    idx_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_EMIT;
                end
            end
            S_EMIT: begin
                // strobe is visible this cycle; advance to the next digit
                shadow_d    = shadow_q << 4;
                idx_d       = idx_q + IDX_W'(1);
                cnt_d       = '0;
                last_data_d = cur_nib;
                last_addr_d = addr_q;
`ifdef POPSHIFT_ADDR_INC_EN
                addr_d      = addr_q + 4'd1;
`else
                addr_d      = addr_q;
`endif
                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                end else if (BACK_TO_BACK) begin
                    state_d = S_EMIT;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // hold freezes both the count and the exit decision, so
                // every held cycle delays the next strobe by exactly one
                if (!iHold) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_EMIT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from state; data/addr hold last strobe when idle
    always_comb begin
        oEn   = (state_q == S_EMIT);
        oData = oEn ? cur_nib : last_data_q;
        oAddr = oEn ? addr_q  : last_addr_q;
        oBusy = (state_q != S_IDLE);
        oDone = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_popshift_loadmod.sv
// Self-checking bench for popshift_loadmod: two instances (step 4 and
// step 1) checked against a timeline model built from the pacing rules.
module tb_popshift_loadmod;

    localparam int N = 6;

    logic        sysclk = 1'b0;
    logic        rst_n  = 1'b0;
    logic        ld4 = 1'b0, ld1 = 1'b0, hold = 1'b0;
    logic [23:0] din  = '0;
    logic [3:0]  base = '0;

    logic       en4, busy4, done4, en1, busy1, done1;
    logic [3:0] addr4, dat4, addr1, dat1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // observed strobes (cycle label, addr, data), done pulses, busy cycles
    int s4_c[$], s4_a[$], s4_d[$], d4_c[$];
    int s1_c[$], s1_a[$], s1_d[$], d1_c[$];
    int b4_n = 0, b1_n = 0;
    // expected timeline
    int e_c[$], e_a[$], e_d[$];
    int e_done, e_busy;

    popshift_loadmod #(.NIBBLES(N), .STEP_CYCLES(4), .CNT_W(8)) u_dut4 (
        .sysclk(sysclk), .rst_n(rst_n), .iLoad(ld4), .iData(din),
        .iBaseAddr(base), .iHold(hold), .oEn(en4), .oAddr(addr4),
        .oData(dat4), .oBusy(busy4), .oDone(done4));

    popshift_loadmod #(.NIBBLES(N), .STEP_CYCLES(1), .CNT_W(4)) u_dut1 (
        .sysclk(sysclk), .rst_n(rst_n), .iLoad(ld1), .iData(din),
        .iBaseAddr(base), .iHold(hold), .oEn(en1), .oAddr(addr1),
        .oData(dat1), .oBusy(busy1), .oDone(done1));

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    // a sample at a negedge is labelled with the edge that will capture it
    always @(negedge sysclk) begin
        if (en4) begin s4_c.push_back(cyc + 1); s4_a.push_back(int'(addr4)); s4_d.push_back(int'(dat4)); end
        if (done4) d4_c.push_back(cyc + 1);
        if (busy4) b4_n++;
        if (en1) begin s1_c.push_back(cyc + 1); s1_a.push_back(int'(addr1)); s1_d.push_back(int'(dat1)); end
        if (done1) d1_c.push_back(cyc + 1);
        if (busy1) b1_n++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Timeline model: first strobe one cycle after acceptance edge k,
    // then every step cycles, plus held cycles before strobe hold_gap.
    function automatic void build_exp(input logic [23:0] w, input logic [3:0] b,
                                      input int step, input int k,
                                      input int hold_gap, input int hold_len);
        int t;
        e_c.delete(); e_a.delete(); e_d.delete();
        t = k + 1;
        for (int i = 0; i < N; i++) begin
            if (i > 0) t += step;
            if (i == hold_gap) t += hold_len;
            e_c.push_back(t);
            e_d.push_back(int'((w >> (4 * (N - 1 - i))) & 24'hF));
`ifdef POPSHIFT_ADDR_INC_EN
            e_a.push_back((int'(b) + i) % 16);
`else
            e_a.push_back(int'(b));
`endif
        end
        e_done = t + 1;
        e_busy = e_done - k;
    endfunction

    task automatic clear_mon();
        s4_c.delete(); s4_a.delete(); s4_d.delete(); d4_c.delete();
        s1_c.delete(); s1_a.delete(); s1_d.delete(); d1_c.delete();
        b4_n = 0; b1_n = 0;
    endtask

    // call at a negedge; returns the acceptance edge number
    task automatic do_load(input bit which, input logic [23:0] w,
                           input logic [3:0] b, output int k);
        din = w; base = b;
        if (which) ld1 = 1'b1; else ld4 = 1'b1;
        k = cyc + 1;
        @(negedge sysclk);
        ld4 = 1'b0; ld1 = 1'b0;
    endtask

    task automatic wait_done(input bit which, input int cnt, input int budget);
        int n = 0;
        while (((which ? d1_c.size() : d4_c.size()) < cnt) && n < budget) begin
            @(negedge sysclk);
            n++;
        end
        repeat (2) @(negedge sysclk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge sysclk);
        checks++;
        if ({en4, addr4, dat4, busy4, done4} !== 11'b0) begin
            failures++; $display("FAIL reset_dut4 got=%h exp=0", {en4, addr4, dat4, busy4, done4});
        end
        checks++;
        if ({en1, addr1, dat1, busy1, done1} !== 11'b0) begin
            failures++; $display("FAIL reset_dut1 got=%h exp=0", {en1, addr1, dat1, busy1, done1});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge sysclk);
        checks++;
        if ({en4, busy4, done4, en1, busy1, done1} !== 6'b0) begin
            failures++; $display("FAIL reset_release got=%b exp=000000", {en4, busy4, done4, en1, busy1, done1});
        end
        clear_mon();
    endtask

    task automatic test_basic();
        int k;
        logic [23:0] w;
        logic [3:0] b;
        for (int it = 0; it < 3; it++) begin
            w = (it == 0) ? 24'h123456 : 24'($urandom);
            b = (it == 0) ? 4'h0 : 4'($urandom);
            clear_mon();
            do_load(1'b0, w, b, k);
            build_exp(w, b, 4, k, -1, 0);
            wait_done(1'b0, 1, 60);
            checks++;
            if (s4_c.size() != N) begin
                failures++; $display("FAIL basic%0d_count got=%0d exp=%0d", it, s4_c.size(), N);
            end else begin
                for (int i = 0; i < N; i++) begin
                    checks++;
                    if (s4_c[i] !== e_c[i] || s4_a[i] !== e_a[i] || s4_d[i] !== e_d[i]) begin
                        failures++;
                        $display("FAIL basic%0d_strobe%0d got cyc=%0d a=%h d=%h exp cyc=%0d a=%h d=%h",
                                 it, i, s4_c[i], s4_a[i], s4_d[i], e_c[i], e_a[i], e_d[i]);
                    end
                end
            end
            checks++;
            if (d4_c.size() != 1 || d4_c[0] != e_done) begin
                failures++; $display("FAIL basic%0d_done got n=%0d cyc=%0d exp cyc=%0d", it, d4_c.size(), d4_c[0], e_done);
            end
            checks++;
            if (b4_n != e_busy) begin
                failures++; $display("FAIL basic%0d_busy got=%0d exp=%0d", it, b4_n, e_busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        int k;
        logic [23:0] w;
        logic [3:0] b;
        for (int it = 0; it < 3; it++) begin
            w = (it == 0) ? 24'hABCDEF : 24'($urandom);
            b = (it == 0) ? 4'hE : 4'($urandom);
            clear_mon();
            do_load(1'b1, w, b, k);
            build_exp(w, b, 1, k, -1, 0);
            wait_done(1'b1, 1, 30);
            checks++;
            if (s1_c.size() != N) begin
                failures++; $display("FAIL b2b%0d_count got=%0d exp=%0d", it, s1_c.size(), N);
            end else begin
                for (int i = 0; i < N; i++) begin
                    checks++;
                    if (s1_c[i] !== e_c[i] || s1_a[i] !== e_a[i] || s1_d[i] !== e_d[i]) begin
                        failures++;
                        $display("FAIL b2b%0d_strobe%0d got cyc=%0d a=%h d=%h exp cyc=%0d a=%h d=%h",
                                 it, i, s1_c[i], s1_a[i], s1_d[i], e_c[i], e_a[i], e_d[i]);
                    end
                end
            end
            checks++;
            if (d1_c.size() != 1 || d1_c[0] != e_done || b1_n != e_busy) begin
                failures++; $display("FAIL b2b%0d_done got cyc=%0d busy=%0d exp cyc=%0d busy=%0d",
                                     it, d1_c[0], b1_n, e_done, e_busy);
            end
        end
    endtask

    task automatic test_hold();
        int k, n, hl;
        logic [23:0] w;
        logic [3:0] b;
        for (int it = 0; it < 2; it++) begin
            w = 24'($urandom);
            b = 4'($urandom);
            hl = (it == 0) ? 10 : int'($urandom_range(1, 15));
            clear_mon();
            do_load(1'b0, w, b, k);
            n = 0;
            while (s4_c.size() < 2 && n < 40) begin @(negedge sysclk); n++; end
            @(negedge sysclk);
            hold = 1'b1;
            repeat (hl) @(negedge sysclk);
            hold = 1'b0;
            build_exp(w, b, 4, k, 2, hl);
            wait_done(1'b0, 1, 80);
            checks++;
            if (s4_c.size() != N) begin
                failures++; $display("FAIL hold%0d_count got=%0d exp=%0d", it, s4_c.size(), N);
            end else begin
                for (int i = 0; i < N; i++) begin
                    checks++;
                    if (s4_c[i] !== e_c[i] || s4_d[i] !== e_d[i]) begin
                        failures++;
                        $display("FAIL hold%0d_strobe%0d got cyc=%0d d=%h exp cyc=%0d d=%h",
                                 it, i, s4_c[i], s4_d[i], e_c[i], e_d[i]);
                    end
                end
            end
            checks++;
            if (d4_c.size() != 1 || d4_c[0] != e_done) begin
                failures++; $display("FAIL hold%0d_done got cyc=%0d exp=%0d", it, d4_c[0], e_done);
            end
        end
    endtask

    task automatic test_busy_protect();
        int k, n, dl;
        logic [23:0] w2;
        logic [3:0] b2;
        w2 = 24'($urandom);
        b2 = 4'($urandom);
        clear_mon();
        do_load(1'b0, 24'h123456, 4'h3, k);
        repeat (2) @(negedge sysclk);
        // intruding load held high through the rest of the run and DONE
        din = 24'hFFFFFF; base = 4'hF; ld4 = 1'b1;
        n = 0;
        while (d4_c.size() < 1 && n < 60) begin @(negedge sysclk); n++; end
        dl = (d4_c.size() > 0) ? d4_c[0] : cyc;
        din = w2; base = b2;
        while (cyc < dl + 1) @(negedge sysclk);
        ld4 = 1'b0;
        build_exp(24'h123456, 4'h3, 4, k, -1, 0);
        checks++;
        if (dl != e_done) begin
            failures++; $display("FAIL busy_first_done got=%0d exp=%0d", dl, e_done);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (s4_c.size() <= i || s4_c[i] !== e_c[i] || s4_d[i] !== e_d[i] || s4_a[i] !== e_a[i]) begin
                failures++;
                $display("FAIL busy_first_strobe%0d got cyc=%0d d=%h exp cyc=%0d d=%h",
                         i, (s4_c.size() > i) ? s4_c[i] : -1, (s4_d.size() > i) ? s4_d[i] : -1, e_c[i], e_d[i]);
            end
        end
        wait_done(1'b0, 2, 60);
        build_exp(w2, b2, 4, dl + 1, -1, 0);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (s4_c.size() <= N + i || s4_c[N + i] !== e_c[i] || s4_d[N + i] !== e_d[i] || s4_a[N + i] !== e_a[i]) begin
                failures++;
                $display("FAIL busy_second_strobe%0d got cyc=%0d d=%h exp cyc=%0d d=%h",
                         i, (s4_c.size() > N + i) ? s4_c[N + i] : -1,
                         (s4_d.size() > N + i) ? s4_d[N + i] : -1, e_c[i], e_d[i]);
            end
        end
        checks++;
        if (d4_c.size() != 2 || d4_c[1] != e_done) begin
            failures++; $display("FAIL busy_second_done got n=%0d cyc=%0d exp cyc=%0d", d4_c.size(), d4_c[1], e_done);
        end
    endtask

    task automatic test_reset_mid();
        int k, n;
        logic [3:0] b;
        clear_mon();
        do_load(1'b0, 24'h123456, 4'h5, k);
        n = 0;
        while (s4_c.size() < 3 && n < 40) begin @(negedge sysclk); n++; end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({en4, addr4, dat4, busy4, done4} !== 11'b0) begin
            failures++; $display("FAIL async_reset got=%h exp=0", {en4, addr4, dat4, busy4, done4});
        end
        repeat (2) @(negedge sysclk);
        clear_mon();
        rst_n = 1'b1;
        repeat (30) @(negedge sysclk);
        checks++;
        if (s4_c.size() != 0 || d4_c.size() != 0 || b4_n != 0) begin
            failures++; $display("FAIL reset_abort got strobes=%0d dones=%0d busy=%0d exp 0 0 0",
                                 s4_c.size(), d4_c.size(), b4_n);
        end
        b = 4'($urandom);
        do_load(1'b0, 24'h000001, b, k);
        build_exp(24'h000001, b, 4, k, -1, 0);
        wait_done(1'b0, 1, 60);
        checks++;
        if (s4_c.size() != N) begin
            failures++; $display("FAIL fresh_count got=%0d exp=%0d", s4_c.size(), N);
        end else begin
            for (int i = 0; i < N; i++) begin
                checks++;
                if (s4_c[i] !== e_c[i] || s4_a[i] !== e_a[i] || s4_d[i] !== e_d[i]) begin
                    failures++;
                    $display("FAIL fresh_strobe%0d got cyc=%0d a=%h d=%h exp cyc=%0d a=%h d=%h",
                             i, s4_c[i], s4_a[i], s4_d[i], e_c[i], e_a[i], e_d[i]);
                end
            end
        end
        checks++;
        if (d4_c.size() != 1 || d4_c[0] != e_done) begin
            failures++; $display("FAIL fresh_done got cyc=%0d exp=%0d", d4_c[0], e_done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_hold();
        test_busy_protect();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
